somador_serial: RTL and testbench

Parametrised, multi-cycle signed adder/subtractor. It is the sequential successor of the 8-bit combinational somador.
- Adds or subtracts two WIDTH-bit two's-complement operands one CHUNK-bit slice per clock, LSB slice first, through a single carry register.
- Runtime choice of wrap-around or saturating result; signed-overflow FLAG and unsigned carry out.
- Valid/ready handshakes on both sides, so it sits between a register-file/operand source and any result consumer.

---
 rtl/somador_pkg.sv | 24 ++
 rtl/somador_serial_if.sv | 31 +++
 rtl/somador_fatia.sv | 18 +
 rtl/somador_serial.sv | 177 +++++++++++++++++
 tb/tb_somador_serial.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/somador_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
//   estado_t  : controller states (IDLE, CALC, DONE)
//   max_pos() : most-positive two's-complement value of a given width (011..1)
//   max_neg() : most-negative two's-complement value of a given width (100..0)
// The helpers return a 64-bit vector; callers cast down to their own width.
package somador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } estado_t;

  localparam int MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH-1:0] max_pos(input int width);
    return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] max_neg(input int width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/somador_serial_if.sv
// Handshake bundle of the serial adder/subtractor.
//   Operand side : in_valid, in_ready, A, B, sub, sat
//   Result side  : out_valid, out_ready, Soma, FLAG, carry_out
// master = operand source / result consumer, slave = the adder itself.
interface somador_serial_if #(
  parameter int WIDTH = 8
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] A;
  logic signed [WIDTH-1:0] B;
  logic                    sub;
  logic                    sat;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] Soma;
  logic                    FLAG;
  logic                    carry_out;

  modport master (
    output in_valid, A, B, sub, sat, out_ready,
    input  in_ready, out_valid, Soma, FLAG, carry_out
  );

  modport slave (
    input  in_valid, A, B, sub, sat, out_ready,
    output in_ready, out_valid, Soma, FLAG, carry_out
  );

endinterface

// File: rtl/somador_fatia.sv
// Combinational CHUNK-bit slice adder: {cout, s} = a + b + cin.
//   a, b : slice operands
//   cin  : carry in from the previous (less significant) slice
//   s    : slice sum
//   cout : carry out towards the next slice
module somador_fatia #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(cin);

endmodule

// File: rtl/somador_serial.sv
// Multi-cycle signed adder/subtractor. WIDTH-bit operands are summed one
// CHUNK-bit slice per clock (LSB slice first) through a single carry register,
// with optional saturation, signed-overflow flag and unsigned carry out.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : somador_serial_if.slave (operand and result valid/ready handshakes)
// An operation accepted at edge k shows out_valid after edge k+NCHUNK; the
// result is held until out_ready, and the block returns to IDLE for one cycle
// before accepting again.
module somador_serial
  import somador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic             clk,
  input logic             rst_n,
  somador_serial_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int MSB    = WIDTH - 1;

  localparam logic [WIDTH-1:0] SAT_POS  = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG  = WIDTH'(max_neg(WIDTH));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  estado_t          state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // B' : B, or ~B when subtracting
  logic [WIDTH-1:0] raw_q, raw_d;  // slice sums accumulated so far
  logic [WIDTH-1:0] res_q, res_d;
  logic             sat_q, sat_d;
  logic             flag_q, flag_d;
  logic             cout_q, cout_d;

  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             cout_sl;
  logic [WIDTH-1:0] raw_nxt;
  logic             last;
  logic             ovf;

  // ---------------------------------------------------------------------------
  // Slice datapath: one adder, selected by the slice index
  // ---------------------------------------------------------------------------
  assign a_sl = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_sl = b_q[int'(idx_q)*CHUNK +: CHUNK];

  somador_fatia #(.CHUNK(CHUNK)) u_fatia (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .s    (s_sl),
    .cout (cout_sl)
  );

  // Full raw sum including the slice being computed this cycle, so the final
  // slice can be finalised without an extra cycle.
  always_comb begin
    raw_nxt = raw_q;
    raw_nxt[int'(idx_q)*CHUNK +: CHUNK] = s_sl;
  end

  assign last = (idx_q == LAST_IDX);
  // Same-sign operands (after B inversion) producing a sum of the other sign.
  assign ovf  = (a_q[MSB] == b_q[MSB]) && (raw_nxt[MSB] != a_q[MSB]);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first; a path that leaves
  // a variable unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = CALC;
      CALC:    if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // in_ready is gated by rst_n so it reads low for the whole reset interval,
  // not only once the state register has been cleared.
  always_comb begin
    bus.in_ready  = rst_n && (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.Soma      = res_q;
    bus.FLAG      = flag_q;
    bus.carry_out = cout_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    raw_d   = raw_q;
    res_d   = res_q;
    sat_d   = sat_q;
    flag_d  = flag_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          // Subtraction as A + ~B + 1: the +1 rides in on the carry register.
          b_d     = bus.sub ? ~bus.B : bus.B;
          carry_d = bus.sub;
          sat_d   = bus.sat;
          idx_d   = '0;
          raw_d   = '0;
        end
      end
      CALC: begin
        raw_d   = raw_nxt;
        carry_d = cout_sl;
        idx_d   = last ? '0 : idx_q + IDX_W'(1);
        if (last) begin
          flag_d = ovf;
          cout_d = cout_sl;
          if (sat_q && ovf) res_d = a_q[MSB] ? SAT_NEG : SAT_POS;
          else              res_d = raw_nxt;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      raw_q   <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      flag_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      raw_q   <= raw_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
      flag_q  <= flag_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_somador_serial.sv
// Bench for somador_serial: three instances (8/4, 16/4, 8/1) share clk/rst_n.
// Stimulus pushes the expected result of every accepted operation into a
// per-instance queue; a negedge monitor compares whenever out_valid is high.
module tb_somador_serial;

  typedef struct {
    logic [15:0] soma;
    logic        flag;
    logic        cout;
    longint      acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-instance drive and observe arrays (index 0: 8/4, 1: 16/4, 2: 8/1)
  logic        iv[3], subv[3], satv[3], orv[3];
  logic [15:0] av[3], bv[3];
  logic        rdy[3], ov[3], ordy[3], fl[3], co[3];
  logic [15:0] so[3];
  logic        rand_bp = 1'b0;
  logic        bp_rnd  = 1'b1;

  exp_t scb[3][$];

  somador_serial_if #(.WIDTH(8))  if0 ();
  somador_serial_if #(.WIDTH(16)) if1 ();
  somador_serial_if #(.WIDTH(8))  if2 ();

  somador_serial #(.WIDTH(8),  .CHUNK(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  somador_serial #(.WIDTH(16), .CHUNK(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  somador_serial #(.WIDTH(8),  .CHUNK(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.in_valid = iv[0];   assign if0.A = av[0][7:0];  assign if0.B = bv[0][7:0];
  assign if0.sub = subv[0];      assign if0.sat = satv[0];   assign if0.out_ready = orv[0];
  assign if1.in_valid = iv[1];   assign if1.A = av[1];       assign if1.B = bv[1];
  assign if1.sub = subv[1];      assign if1.sat = satv[1];   assign if1.out_ready = orv[1];
  assign if2.in_valid = iv[2];   assign if2.A = av[2][7:0];  assign if2.B = bv[2][7:0];
  assign if2.sub = subv[2];      assign if2.sat = satv[2];
  assign if2.out_ready = rand_bp ? bp_rnd : orv[2];

  assign rdy[0] = if0.in_ready;  assign ov[0] = if0.out_valid;  assign ordy[0] = if0.out_ready;
  assign so[0] = {8'h00, if0.Soma};  assign fl[0] = if0.FLAG;   assign co[0] = if0.carry_out;
  assign rdy[1] = if1.in_ready;  assign ov[1] = if1.out_valid;  assign ordy[1] = if1.out_ready;
  assign so[1] = if1.Soma;       assign fl[1] = if1.FLAG;       assign co[1] = if1.carry_out;
  assign rdy[2] = if2.in_ready;  assign ov[2] = if2.out_valid;  assign ordy[2] = if2.out_ready;
  assign so[2] = {8'h00, if2.Soma};  assign fl[2] = if2.FLAG;   assign co[2] = if2.carry_out;

  always @(posedge clk) begin
    #1 bp_rnd = ($urandom_range(0, 3) != 0);
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, expv, expv, cyc);
    end
  endtask

  function automatic int wid(input int u);
    return (u == 1) ? 16 : 8;
  endfunction

  function automatic int nch(input int u);
    return (u == 0) ? 2 : (u == 1) ? 4 : 8;
  endfunction

  // Reference: exact integer arithmetic, then range test for overflow.
  function automatic exp_t model(input int u, input longint a, input longint b,
                                 input bit s, input bit st);
    exp_t   e;
    int     w    = wid(u);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = a & m;
    longint ub   = b & m;
    longint sa   = (ua >= half) ? ua - (m + 1) : ua;
    longint sb   = (ub >= half) ? ub - (m + 1) : ub;
    longint t    = s ? sa - sb : sa + sb;
    bit     ovf  = (t > half - 1) || (t < -half);
    longint r    = (st && ovf) ? ((t > 0) ? half - 1 : -half) : t;
    e.soma = 16'(r & m);
    e.flag = ovf;
    e.cout = s ? (ua >= ub) : ((ua + ub) > m);
    e.acc  = 0;
    return e;
  endfunction

  function automatic longint pick(input int u);
    longint half = longint'(1) << (wid(u) - 1);
    case ($urandom_range(0, 7))
      0:       return half - 1;
      1:       return -half;
      2:       return 0;
      3:       return -1;
      default: return longint'($urandom) & ((longint'(1) << wid(u)) - 1);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int u, input longint a, input longint b,
                       input bit s, input bit st);
    int   n = 0;
    exp_t e;
    while (!rdy[u] && n < 200) begin
      tick();
      n++;
    end
    if (!rdy[u]) begin
      check($sformatf("u%0d accept timeout", u), 0, 1);
      return;
    end
    av[u] = 16'(a);  bv[u] = 16'(b);  subv[u] = s;  satv[u] = st;  iv[u] = 1'b1;
    tick();
    e = model(u, a, b, s, st);
    e.acc = cyc;
    scb[u].push_back(e);
    iv[u] = 1'b0;
  endtask

  task automatic wait_valid(input int u);
    int n = 0;
    while (!ov[u] && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("u%0d out_valid wait", u), ov[u], 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((scb[0].size() + scb[1].size() + scb[2].size()) != 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain pending", scb[0].size() + scb[1].size() + scb[2].size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("%s u%0d in_ready", tag, u), rdy[u], 0);
      check($sformatf("%s u%0d out_valid", tag, u), ov[u], 0);
      check($sformatf("%s u%0d Soma", tag, u), so[u], 0);
      check($sformatf("%s u%0d FLAG", tag, u), fl[u], 0);
      check($sformatf("%s u%0d carry_out", tag, u), co[u], 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic pov[3];
  exp_t me;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int u = 0; u < 3; u++) pov[u] = 1'b0;
    end else begin
      for (int u = 0; u < 3; u++) begin
        if (scb[u].size() != 0) check($sformatf("u%0d in_ready while busy", u), rdy[u], 0);
        if (ov[u]) begin
          if (scb[u].size() == 0) begin
            check($sformatf("u%0d unexpected out_valid", u), 1, 0);
          end else begin
            me = scb[u][0];
            if (!pov[u]) check($sformatf("u%0d latency", u), cyc - me.acc, nch(u));
            check($sformatf("u%0d Soma", u), so[u], me.soma);
            check($sformatf("u%0d FLAG", u), fl[u], me.flag);
            check($sformatf("u%0d carry_out", u), co[u], me.cout);
            if (ordy[u]) void'(scb[u].pop_front());
          end
        end
        pov[u] = ov[u];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int u = 0; u < 3; u++) begin
      iv[u] = 0; subv[u] = 0; satv[u] = 0; orv[u] = 1; av[u] = '0; bv[u] = '0;
    end

    #12;
    check_reset_outputs("in reset");
    #10 rst_n = 1'b1;
    tick();
    for (int u = 0; u < 3; u++) check($sformatf("u%0d in_ready after reset", u), rdy[u], 1);

    // Directed 8-bit, CHUNK=4
    issue(0, 9, 2, 0, 0);
    issue(0, 127, -17, 0, 0);
    issue(0, -127, -2, 0, 0);
    issue(0, -127, -2, 0, 1);
    issue(0, 101, 111, 0, 0);
    issue(0, 101, 111, 0, 1);
    issue(0, -128, 1, 1, 0);
    issue(0, -128, 1, 1, 1);
    issue(0, 5, 5, 1, 0);
    issue(0, 3, -128, 1, 0);
    issue(0, -3, -128, 1, 1);

    // Directed 16-bit, CHUNK=4
    issue(1, 32767, 1, 0, 1);
    issue(1, -32768, 32767, 1, 1);
    drain();

    // Backpressure: result held 5 cycles, in_valid pulses ignored
    orv[0] = 1'b0;
    issue(0, 50, -20, 0, 0);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      iv[0] = (i % 2 == 0);
      av[0] = 16'h0055;
      bv[0] = 16'h0044;
      tick();
    end
    iv[0]  = 1'b0;
    orv[0] = 1'b1;
    tick();
    check("u0 in_ready after handoff", rdy[0], 1);
    check("u0 out_valid after handoff", ov[0], 0);
    issue(0, -100, 27, 1, 0);
    drain();

    // Reset one cycle into CALC
    issue(0, 20, 30, 0, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-CALC reset");
    for (int u = 0; u < 3; u++) scb[u].delete();
    tick();
    rst_n = 1'b1;
    tick();
    for (int u = 0; u < 3; u++) check($sformatf("u%0d in_ready after mid-CALC reset", u), rdy[u], 1);
    repeat (10) tick();

    // Reset while a result is waiting in DONE
    orv[0] = 1'b0;
    issue(0, -60, -70, 0, 1);
    wait_valid(0);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-DONE reset");
    for (int u = 0; u < 3; u++) scb[u].delete();
    orv[0] = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("u0 in_ready after mid-DONE reset", rdy[0], 1);

    // Random: short runs on the CHUNK=4 instances
    for (int i = 0; i < 30; i++) begin
      issue(0, pick(0), pick(0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      issue(1, pick(1), pick(1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    // Random: 200 ops on the bit-serial instance with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      issue(2, pick(2), pick(2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    rand_bp = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
